riscv_mem_ctrl: RTL and testbench

- Parametrised data-memory block for the rv32im/rv64 core, successor to the fixed 32-bit single-cycle data memory.
- Accepts one load/store request at a time over a valid/ready handshake and models a configurable access latency.
- Handles byte, half, word and double accesses with RISC-V sign/zero extension.
- Reports misaligned, illegal-size and out-of-range accesses instead of silently corrupting memory.

---
 rtl/riscv_mem_ctrl_pkg.sv | 23 ++
 rtl/riscv_mem_ctrl_if.sv | 27 ++
 rtl/riscv_mem_ctrl_align.sv | 45 ++++
 rtl/riscv_mem_ctrl.sv | 118 +++++++++++
 tb/tb_riscv_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states
// and a helper giving the byte count of an access.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
    function automatic int lane_bytes(input mem_size_e size);
        return int'(1) << size;
    endfunction

endpackage

// File: rtl/riscv_mem_ctrl_if.sv
// Request/response bus between the core (master) and the data memory (slave).
interface riscv_mem_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/riscv_mem_ctrl_align.sv
// Byte-lane steering for one storage word: load extraction with sign/zero
// extension, store merge into the addressed lanes, and alignment check.
module riscv_mem_align
    import riscv_mem_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  word_i,
    input  logic [OFF_W-1:0] offset_i,
    input  mem_size_e        size_i,
    input  logic             unsigned_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  load_data_o,
    output logic [XLEN-1:0]  store_word_o,
    output logic             misaligned_o
);
    localparam int NBYTES = XLEN / 8;

    int              n_bytes;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] byte_mask;
    logic [XLEN-1:0] lane_mask;
    logic            sign_bit;

    // Extract/extend the loaded lanes and merge store data into the old word.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment so no latch is inferred.
        n_bytes   = lane_bytes(size_i);
        shifted   = word_i >> (8 * offset_i);
        byte_mask = '0;
        sign_bit  = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i < n_bytes) byte_mask[8*i +: 8] = 8'hFF;
            if (i == n_bytes - 1) sign_bit = shifted[8*i + 7];
        end
        // A full-width access has an all-ones mask, so extension is a no-op.
        if (!unsigned_i && sign_bit) load_data_o = (shifted & byte_mask) | ~byte_mask;
        else                         load_data_o = shifted & byte_mask;
        lane_mask    = byte_mask << (8 * offset_i);
        store_word_o = ((wdata_i << (8 * offset_i)) & lane_mask) | (word_i & ~lane_mask);
        misaligned_o = (int'(offset_i) & (n_bytes - 1)) != 0;
    end

endmodule

// File: rtl/riscv_mem_ctrl.sv
// Data memory with valid/ready request and response channels, a fixed
// access latency, sub-word loads/stores and fault reporting.
module riscv_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 2
) (
    input logic                clk,
    input logic                reset,
    riscv_mem_ctrl_if.slave    bus
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    mem_size_e         size_q;
    logic              we_q;
    logic              uns_q;
    logic [XLEN-1:0]   wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [XLEN-1:0]   rsp_rdata_q;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic [ADDR_W-OFF_W-1:0] word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    in_range;
    logic [XLEN-1:0]         rd_word;
    logic [XLEN-1:0]         load_data;
    logic [XLEN-1:0]         store_word;
    logic                    misaligned;
    logic                    err_d;
    logic [XLEN-1:0]         rdata_d;
    logic                    commit;

    assign word_idx = addr_q[ADDR_W-1:OFF_W];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = 64'(word_idx) < 64'(DEPTH_WORDS);
    assign rd_word  = in_range ? mem[mem_idx] : '0;

    riscv_mem_align #(.XLEN(XLEN)) u_align (
        .word_i       (rd_word),
        .offset_i     (addr_q[OFF_W-1:0]),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word),
        .misaligned_o (misaligned)
    );

    // Doubles only exist on a 64-bit datapath; faults return zero data.
    assign err_d   = misaligned || (size_q == MEM_D && XLEN != 64) || !in_range;
    assign rdata_d = (err_d || we_q) ? '0 : load_data;
    assign commit  = (state_q == BUSY) && (cnt_q == '0) && we_q && !err_d;

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Request/latency/response FSM; request fields are latched on accept.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        size_q  <= mem_size_e'(bus.req_size);
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_d;
                        rsp_rdata_q <= rdata_d;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store commit into the addressed word; reset aborts a pending write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; only control state is initialised.
        if (!reset && commit) mem[mem_idx] <= store_word;
    end

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// Scoreboard bench: the driver pushes expected responses computed by a
// byte-addressed reference model; a monitor pops and compares on handshake.
module tb_riscv_mem_ctrl;
    import riscv_mem_pkg::*;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic reset;

    riscv_mem_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    riscv_mem_ctrl #(
        .XLEN(XLEN), .DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          compared   = 0;
    int          mismatched = 0;
    bit [7:0]    ref_mem [bit [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with RISC-V access rules.
    function automatic void model(input bit we, input bit [1:0] size, input bit uns,
                                  input bit [31:0] addr, input bit [31:0] wdata,
                                  output bit [31:0] rdata, output bit err);
        int     n;
        longint v;
        n     = 1 << size;
        rdata = '0;
        err   = (size == 2'd3) || (addr % n != 0) || ((addr / 4) >= DEPTH);
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            rdata = v[31:0];
        end
    endfunction

    // Monitor: one comparison per response handshake.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rsp: got a response, required none pending");
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_rdata"}, 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                check({mon_e.name, "_err"}, 64'(bus.rsp_err), 64'(mon_e.err));
            end
        end
    end

    // Issue one request; hold > 0 keeps rsp_ready low that many edges after rsp_valid.
    task automatic issue(input string name, input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         input bit use_exp, input bit [31:0] exp_rdata, input bit exp_err,
                         input int hold);
        bit [31:0] m_rd;
        bit        m_err;
        exp_t      e;
        int        n;
        model(we, size, uns, addr, wdata, m_rd, m_err);
        e.name  = name;
        e.rdata = use_exp ? exp_rdata : m_rd;
        e.err   = use_exp ? exp_err : m_err;
        sb_q.push_back(e);
        check({name, "_ready_idle"}, 64'(bus.req_ready), 64'd1);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = (hold == 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check({name, "_ready_busy"}, 64'(bus.req_ready), 64'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.rsp_valid && n < 20);
        check({name, "_latency"}, 64'(n), 64'(LAT));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                check({name, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
                check({name, "_hold_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
                check({name, "_hold_err"}, 64'(bus.rsp_err), 64'(e.err));
                check({name, "_hold_ready"}, 64'(bus.req_ready), 64'd0);
                // A stray store of zero to 0x10 must not be accepted here.
                bus.req_we    = 1'b1;
                bus.req_size  = 2'd2;
                bus.req_addr  = 32'h10;
                bus.req_wdata = 32'h0;
                bus.req_valid = (k == 1);
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({name, "_valid_clr"}, 64'(bus.rsp_valid), 64'd0);
        check({name, "_ready_back"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic ld(input string name, input bit [1:0] size, input bit uns, input bit [31:0] addr,
                      input bit [31:0] exp_rdata, input bit exp_err);
        issue(name, 1'b0, size, uns, addr, 32'h0, 1'b1, exp_rdata, exp_err, 0);
    endtask

    task automatic st(input string name, input bit [1:0] size, input bit [31:0] addr,
                      input bit [31:0] wdata, input bit exp_err);
        issue(name, 1'b1, size, 1'b0, addr, wdata, 1'b1, 32'h0, exp_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit [1:0]  r_size;
        bit [31:0] r_addr;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.req_ready), 64'd1);

        // Store then load.
        st("sw_10", 2'd2, 32'h10, 32'hDEADBEEF, 1'b0);
        ld("lw_10", 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        // Sub-word loads.
        ld("lb_13",  2'd0, 1'b0, 32'h13, 32'hFFFFFFDE, 1'b0);
        ld("lbu_13", 2'd0, 1'b1, 32'h13, 32'h000000DE, 1'b0);
        ld("lh_12",  2'd1, 1'b0, 32'h12, 32'hFFFFDEAD, 1'b0);
        ld("lhu_12", 2'd1, 1'b1, 32'h12, 32'h0000DEAD, 1'b0);
        ld("lb_10",  2'd0, 1'b0, 32'h10, 32'hFFFFFFEF, 1'b0);
        ld("lwu_10", 2'd2, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        // Partial stores.
        st("sb_11", 2'd0, 32'h11, 32'hFFFFFF55, 1'b0);
        ld("lw_sb", 2'd2, 1'b0, 32'h10, 32'hDEAD55EF, 1'b0);
        st("sh_10", 2'd1, 32'h10, 32'h00001234, 1'b0);
        ld("lw_sh", 2'd2, 1'b0, 32'h10, 32'hDEAD1234, 1'b0);
        // Faults.
        st("sh_13_mis", 2'd1, 32'h13, 32'hAAAA5555, 1'b1);
        ld("lw_after_fault", 2'd2, 1'b0, 32'h10, 32'hDEAD1234, 1'b0);
        ld("lw_12_mis", 2'd2, 1'b0, 32'h12, 32'h0, 1'b1);
        ld("lw_1000_oor", 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1);
        st("sw_ffc_last", 2'd2, 32'hFFC, 32'h0BADF00D, 1'b0);
        ld("lw_ffc_last", 2'd2, 1'b0, 32'hFFC, 32'h0BADF00D, 1'b0);
        ld("ld_size3", 2'd3, 1'b0, 32'h10, 32'h0, 1'b1);
        st("sd_size3", 2'd3, 32'h10, 32'h11111111, 1'b1);
        ld("lw_after_sd", 2'd2, 1'b0, 32'h10, 32'hDEAD1234, 1'b0);
        // Backpressure, then confirm the stray store pulse was ignored.
        issue("lw_bp", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD1234, 1'b0, 5);
        ld("lw_after_bp", 2'd2, 1'b0, 32'h10, 32'hDEAD1234, 1'b0);

        // Reset one cycle after accepting a store: no response, no write.
        st("sw_20", 2'd2, 32'h20, 32'hCAFEF00D, 1'b0);
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h12345678;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        reset = 1'b0;
        #1;
        check("abort_ready", 64'(bus.req_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        ld("lw_20_kept", 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);

        // Randomised traffic over a pre-filled window plus out-of-range hits.
        for (int w = 0; w < 16; w++)
            issue("fill", 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * w), $urandom, 1'b0, 32'h0, 1'b0, 0);
        for (int t = 0; t < 120; t++) begin
            r_size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) r_addr = 32'h1000 + 32'($urandom_range(0, 65535));
            else                           r_addr = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
            issue("rnd", 1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)),
                  r_addr, $urandom, 1'b0, 32'h0, 1'b0, (t % 17 == 5) ? 2 : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
